stopwatch_lap_core: RTL and testbench



---
 rtl/sw_pkg.sv | 57 +++++
 rtl/sw_tick_gen.sv | 29 ++
 rtl/stopwatch_lap_core.sv | 136 +++++++++++++
 tb/tb_stopwatch_lap_core.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared types and helpers for the MM:SS stopwatch: state encoding,
// BCD increment, seven-segment decode and active-low anode patterns.
package sw_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } sw_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] SEL_NONE  = 4'b1111;
  localparam logic [3:0] SEL_DIG0  = 4'b1110;
  localparam logic [3:0] SEL_DIG1  = 4'b1101;
  localparam logic [3:0] SEL_DIG2  = 4'b1011;
  localparam logic [3:0] SEL_DIG3  = 4'b0111;

  function automatic logic [3:0] sel_for_idx(input logic [1:0] idx);
    logic [3:0] s;
    case (idx)
      2'd0:    s = SEL_DIG0;
      2'd1:    s = SEL_DIG1;
      2'd2:    s = SEL_DIG2;
      default: s = SEL_DIG3;
    endcase
    return s;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 is blanked.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Two-digit BCD {tens,ones} increment modulo 60.
  function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/sw_tick_gen.sv
// Free-running 0..N-1 cycle counter; tick is high for the single cycle at N-1.
// clr holds the count at 0 and suppresses the tick.
module sw_tick_gen #(
  parameter int unsigned N = 10
) (
  input  logic clk,
  input  logic RESET,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    if (clr || (cnt_q == LAST)) cnt_d = '0;
    else                        cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/stopwatch_lap_core.sv
// MM:SS stopwatch with run/pause, field adjust, lap hold and a registered
// multiplexed 4-digit seven-segment driver.
//   state     | meaning
//   ST_RUN    | seconds advance on every one-Hz tick
//   ST_PAUSED | time frozen, display still scanning
//   ST_ADJUST | ADJ high; selected field steps on two-Hz ticks, saved_q holds return state
module stopwatch_lap_core
  import sw_pkg::*;
#(
  parameter int unsigned ONE_HZ_CYC = 100_000_000,
  parameter int unsigned TWO_HZ_CYC = 50_000_000,
  parameter int unsigned SCAN_CYC   = 200_000,
  parameter int unsigned BLINK_CYC  = 25_000_000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       PAUSE,
  input  logic       LAP,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [6:0] dispDigit,
  output logic [3:0] selector
);

  sw_state_e  state_q, state_d, saved_q, saved_d;
  logic [7:0] sec_q, sec_d, min_q, min_d;
  logic [7:0] snap_sec_q, snap_sec_d, snap_min_q, snap_min_d;
  logic       lap_q, lap_d;
  logic       pause_prev_q, lap_prev_q;
  logic [1:0] idx_q;
  logic       blink_q;
  logic [3:0] sel_q, sel_d;
  logic [6:0] seg_q, seg_d;

  logic tick_one, tick_two, tick_scan, tick_blink;
  logic one_clr, pause_edge, lap_edge, blank;
  logic [7:0] src_sec, src_min;
  logic [3:0] digit;

  // Cleared for the whole adjust session and the return cycle so counting restarts from 0.
  assign one_clr = ADJ || (state_q == ST_ADJUST);

  sw_tick_gen #(.N(ONE_HZ_CYC)) u_tick_one   (.clk(clk), .RESET(RESET), .clr(one_clr), .tick(tick_one));
  sw_tick_gen #(.N(TWO_HZ_CYC)) u_tick_two   (.clk(clk), .RESET(RESET), .clr(1'b0),    .tick(tick_two));
  sw_tick_gen #(.N(SCAN_CYC))   u_tick_scan  (.clk(clk), .RESET(RESET), .clr(1'b0),    .tick(tick_scan));
  sw_tick_gen #(.N(BLINK_CYC))  u_tick_blink (.clk(clk), .RESET(RESET), .clr(1'b0),    .tick(tick_blink));

  assign pause_edge = PAUSE && !pause_prev_q;
  assign lap_edge   = LAP && !lap_prev_q;

  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    sec_d      = sec_q;
    min_d      = min_q;
    lap_d      = lap_q;
    snap_sec_d = snap_sec_q;
    snap_min_d = snap_min_q;
    if (ADJ) begin
      if (state_q != ST_ADJUST) saved_d = state_q;
      state_d = ST_ADJUST;
      lap_d   = 1'b0;
      if (tick_two) begin
        if (SEL) sec_d = bcd60_inc(sec_q);
        else     min_d = bcd60_inc(min_q);
      end
    end else if (state_q == ST_ADJUST) begin
      state_d = saved_q;
    end else begin
      // Snapshot uses the pre-increment time when a tick lands on the same cycle.
      if (lap_edge) begin
        lap_d = !lap_q;
        if (!lap_q) begin
          snap_sec_d = sec_q;
          snap_min_d = min_q;
        end
      end
      if ((state_q == ST_RUN) && tick_one) begin
        sec_d = bcd60_inc(sec_q);
        if (sec_q == 8'h59) min_d = bcd60_inc(min_q);
      end
      if (pause_edge) state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
    end
  end

  assign src_sec = lap_q ? snap_sec_q : sec_q;
  assign src_min = lap_q ? snap_min_q : min_q;

  always_comb begin
    case (idx_q)
      2'd0:    digit = src_sec[3:0];
      2'd1:    digit = src_sec[7:4];
      2'd2:    digit = src_min[3:0];
      default: digit = src_min[7:4];
    endcase
    blank = ADJ && blink_q && (SEL ? !idx_q[1] : idx_q[1]);
    sel_d = blank ? SEL_NONE  : sel_for_idx(idx_q);
    seg_d = blank ? SEG_BLANK : bcd_to_seg(digit);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q      <= ST_RUN;
      saved_q      <= ST_RUN;
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      snap_sec_q   <= 8'h00;
      snap_min_q   <= 8'h00;
      lap_q        <= 1'b0;
      pause_prev_q <= 1'b0;
      lap_prev_q   <= 1'b0;
      idx_q        <= 2'd0;
      blink_q      <= 1'b0;
      sel_q        <= SEL_DIG0;
      seg_q        <= bcd_to_seg(4'd0);
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      snap_sec_q   <= snap_sec_d;
      snap_min_q   <= snap_min_d;
      lap_q        <= lap_d;
      pause_prev_q <= PAUSE;
      lap_prev_q   <= LAP;
      idx_q        <= idx_q + {1'b0, tick_scan};
      blink_q      <= blink_q ^ tick_blink;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
    end
  end

  assign selector  = sel_q;
  assign dispDigit = seg_q;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Scoreboard bench: a seconds-as-integer reference model predicts every
// registered display output; a monitor pops and compares each cycle.
module tb_stopwatch_lap_core;

  localparam int ONE   = 10;
  localparam int TWO   = 5;
  localparam int SCAN  = 2;
  localparam int BLINK = 4;

  logic       clk = 1'b0;
  logic       RESET = 1'b1, PAUSE = 1'b0, LAP = 1'b0, ADJ = 1'b0, SEL = 1'b0;
  logic [6:0] dispDigit;
  logic [3:0] selector;

  stopwatch_lap_core #(
    .ONE_HZ_CYC(ONE), .TWO_HZ_CYC(TWO), .SCAN_CYC(SCAN), .BLINK_CYC(BLINK)
  ) dut (
    .clk(clk), .RESET(RESET), .PAUSE(PAUSE), .LAP(LAP), .ADJ(ADJ), .SEL(SEL),
    .dispDigit(dispDigit), .selector(selector)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle_no = 0;
  bit   stim_done = 0;

  // Reference model: time as total seconds 0..3599, counters as plain cycle counts.
  int m_time, m_snap, m_c1, m_c2, m_cs, m_cb, m_idx;
  bit m_running, m_saved_run, m_in_adj, m_lap, m_blink, m_pp, m_lp;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit p, input bit l, input bit a, input bit s);
    exp_t e;
    bit adj_was, t1, t2, ts, tb, blank;
    int src, mm, ss, dig;
    if (r) begin
      m_time = 0; m_snap = 0; m_c1 = 0; m_c2 = 0; m_cs = 0; m_cb = 0; m_idx = 0;
      m_running = 1; m_saved_run = 1; m_in_adj = 0; m_lap = 0; m_blink = 0;
      e.sel = 4'b1110;
      e.seg = 7'b1000000;
      m_pp = 0; m_lp = 0;
    end else begin
      adj_was = m_in_adj;
      t1 = (m_c1 == ONE - 1) && !(a || adj_was);
      t2 = (m_c2 == TWO - 1);
      ts = (m_cs == SCAN - 1);
      tb = (m_cb == BLINK - 1);
      src = m_lap ? m_snap : m_time;
      mm = src / 60;
      ss = src % 60;
      case (m_idx)
        0: dig = ss % 10;
        1: dig = ss / 10;
        2: dig = mm % 10;
        default: dig = mm / 10;
      endcase
      blank = a && m_blink && (s ? (m_idx < 2) : (m_idx >= 2));
      e.sel = blank ? 4'b1111 : ~(4'b0001 << m_idx);
      e.seg = blank ? 7'h7F : seg_of(dig);
      if (a) begin
        if (!adj_was) m_saved_run = m_running;
        m_in_adj = 1;
        m_lap = 0;
        if (t2) begin
          if (s) m_time = (m_time / 60) * 60 + ((m_time % 60) + 1) % 60;
          else   m_time = (((m_time / 60) + 1) % 60) * 60 + m_time % 60;
        end
      end else if (adj_was) begin
        m_in_adj = 0;
        m_running = m_saved_run;
      end else begin
        if (l && !m_lp) begin
          m_lap = !m_lap;
          if (m_lap) m_snap = m_time;
        end
        if (m_running && t1) m_time = (m_time + 1) % 3600;
        if (p && !m_pp) m_running = !m_running;
      end
      m_c1 = (a || adj_was) ? 0 : (m_c1 + 1) % ONE;
      m_c2 = (m_c2 + 1) % TWO;
      m_cs = (m_cs + 1) % SCAN;
      m_cb = (m_cb + 1) % BLINK;
      if (ts) m_idx = (m_idx + 1) % 4;
      if (tb) m_blink = !m_blink;
      m_pp = p;
      m_lp = l;
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit p, input bit l, input bit a, input bit s);
    RESET = r; PAUSE = p; LAP = l; ADJ = a; SEL = s;
    model_step(r, p, l, a, s);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit r, input bit p, input bit l, input bit a, input bit s);
    for (int i = 0; i < n; i++) cyc(r, p, l, a, s);
  endtask

  // Monitor: one registered output pair per cycle, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cycle_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({selector, dispDigit} !== {e.sel, e.seg}) begin
          failures++;
          if (failures <= 20)
            $display("FAIL display cyc=%0d selector got=%b want=%b dispDigit got=%b want=%b",
                     cycle_no, selector, e.sel, dispDigit, e.seg);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired cyc=%0d pending=%0d", cycle_no, exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    int len;
    bit r, p, l, a, s;
    // Reset, count to 01:00 and on to the 59:59 -> 00:00 wrap.
    run(2, 1, 0, 0, 0, 0);
    run(600, 0, 0, 0, 0, 0);
    run(35400 + 20, 0, 0, 0, 0, 0);
    // Pause at cycle 35, hold 100 cycles, resume.
    run(1, 1, 0, 0, 0, 0);
    run(35, 0, 0, 0, 0, 0);
    run(3, 0, 1, 0, 0, 0);
    run(100, 0, 0, 0, 0, 0);
    run(3, 0, 1, 0, 0, 0);
    run(30, 0, 0, 0, 0, 0);
    // Adjust minutes for 25 cycles, then seconds across the 59 -> 00 wrap.
    run(1, 1, 0, 0, 0, 0);
    run(25, 0, 0, 0, 1, 0);
    run(10, 0, 0, 0, 0, 0);
    run(1, 1, 0, 0, 0, 0);
    run(300, 0, 0, 0, 1, 1);
    run(20, 0, 0, 0, 0, 0);
    // Lap hold at 00:07 for 50 cycles, then release.
    run(1, 1, 0, 0, 0, 0);
    run(70, 0, 0, 0, 0, 0);
    run(2, 0, 0, 1, 0, 0);
    run(50, 0, 0, 0, 0, 0);
    run(2, 0, 0, 1, 0, 0);
    run(30, 0, 0, 0, 0, 0);
    // Adjust to 12:34, then reset in the middle of adjust.
    run(1, 1, 0, 0, 0, 0);
    run(60, 0, 0, 0, 1, 0);
    run(170, 0, 0, 0, 1, 1);
    run(1, 1, 0, 0, 1, 1);
    run(20, 0, 0, 0, 0, 0);
    // Randomised held-level segments.
    for (int k = 0; k < 300; k++) begin
      len = $urandom_range(1, 30);
      r = ($urandom_range(0, 39) == 0);
      p = $urandom_range(0, 1);
      l = $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0);
      s = $urandom_range(0, 1);
      run(r ? 1 : len, r, p, l, a, s);
    end
    stim_done = 1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
